// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the UART console transmitter.
// UART_TX_PARITY_EN adds the PARITY state (even parity, 10-bit frames).
package uart_tx_fifo_pkg;

    localparam int UART_CHAR_WIDTH = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_char_fifo.sv
// Synchronous FIFO with combinational first-word read data.
// Pushes while full and pops while empty are ignored.
module char_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push)
                wr_q <= wr_q + PW'(1);
            if (do_pop)
                rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 7 data bits LSB-first, 1 stop bit.
// Define UART_TX_PARITY_EN for an even-parity bit after the data.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8,
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [UART_CHAR_WIDTH-1:0] char_in,
    input  logic                       char_valid,
    output logic                       char_ready,
    output logic                       txd,
    output logic                       busy,
    output logic [LW-1:0]              level,
    output logic                       overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_t             state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [UART_CHAR_WIDTH-1:0] shift_q, shift_d;
    logic                       par_q, par_d;
    logic                       txd_q, txd_d;
    logic                       ovf_q;

    logic [UART_CHAR_WIDTH-1:0] fifo_dout;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       bit_end;

    char_fifo #(
        .WIDTH (UART_CHAR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (char_valid),
        .din_i   (char_in),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign bit_end    = (cnt_q == CNT_MAX);
    assign char_ready = !fifo_full;
    assign txd        = txd_q;
    assign busy       = (state_q != IDLE) || (level != '0);
    assign overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            if (char_valid && fifo_full)
                ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!fifo_empty) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA:
                if (bit_end && idx_q == 3'd6)
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
            PARITY: if (bit_end) state_d = STOP;
`else
                    state_d = STOP;
`endif
            STOP:
                if (bit_end)
                    state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Timer idles at zero so every frame starts on a fresh bit period.
    always_comb begin
        pop     = 1'b0;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = ^fifo_dout;
                    txd_d   = 1'b0;
                end
            end
            START:
                if (bit_end) begin
                    txd_d = shift_q[0];
                    idx_d = '0;
                end
            DATA:
                if (bit_end) begin
                    if (idx_q == 3'd6) begin
`ifdef UART_TX_PARITY_EN
                        txd_d = par_q;
`else
                        txd_d = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
            PARITY:
                if (bit_end) txd_d = 1'b1;
`endif
            STOP:
                if (bit_end && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = ^fifo_dout;
                    txd_d   = 1'b0;
                end
            default: txd_d = 1'b1;
        endcase
    end

endmodule
